// File: rtl/second_minimum_scan.sv
// Finds the lowest-amplitude bin in the second BRAM and reports its carrier position as low_time.
// Scan takes num_bins + RD_LATENCY + 2 cycles; scan_start is dropped while busy (no backpressure, no queueing).
module second_minimum_scan #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int BIN_SHIFT  = 7,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  scan_start,
    input  logic [16:0]           msf_frequency,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_rddata,
    output logic [16:0]           low_time,
    output logic [DATA_WIDTH-1:0] min_value,
    output logic                  scan_busy,
    output logic                  scan_done
);

    localparam logic [31:0] NB_MAX    = 32'(1) << ADDR_WIDTH;
    localparam logic [31:0] BIN_ROUND = 32'((1 << BIN_SHIFT) - 1);
    localparam int          LT_W      = ADDR_WIDTH + BIN_SHIFT + 17;
    localparam logic [2:0]  DRAIN_END = 3'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_COMMIT
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   last_addr_q, last_addr_d;
    logic                    bram_en_q, bram_en_d;
    logic [ADDR_WIDTH-1:0]   bram_addr_q, bram_addr_d;
    logic [RD_LATENCY-1:0]   vld_pipe_q, vld_pipe_d;
    logic [2:0]              drain_cnt_q, drain_cnt_d;
    logic [DATA_WIDTH-1:0]   run_min_q, run_min_d;
    logic [ADDR_WIDTH-1:0]   run_idx_q, run_idx_d;
    logic [ADDR_WIDTH-1:0]   rd_idx_q, rd_idx_d;
    logic                    first_q, first_d;
    logic [16:0]             low_time_q, low_time_d;
    logic [DATA_WIDTH-1:0]   min_value_q, min_value_d;
    logic                    scan_busy_q, scan_busy_d;
    logic                    scan_done_q, scan_done_d;

    logic [31:0]             freq_sum;
    logic [31:0]             nb_raw;
    logic [ADDR_WIDTH-1:0]   last_addr_calc;
    logic [LT_W-1:0]         lt_wide;

    // Bin count is stored as the last address to issue, so 2^ADDR_WIDTH bins fit the counter width.
    always_comb begin
        freq_sum = 32'(msf_frequency) + BIN_ROUND;
        nb_raw   = freq_sum >> BIN_SHIFT;
        if (nb_raw == 32'd0) begin
            last_addr_calc = '0;
        end else if (nb_raw > NB_MAX) begin
            last_addr_calc = '1;
        end else begin
            last_addr_calc = ADDR_WIDTH'(nb_raw - 32'd1);
        end
    end

    always_comb begin
        lt_wide = LT_W'(run_idx_q) << BIN_SHIFT;
    end

    always_comb begin
        state_d     = state_q;
        last_addr_d = last_addr_q;
        bram_en_d   = bram_en_q;
        bram_addr_d = bram_addr_q;
        drain_cnt_d = drain_cnt_q;
        run_min_d   = run_min_q;
        run_idx_d   = run_idx_q;
        rd_idx_d    = rd_idx_q;
        first_d     = first_q;
        low_time_d  = low_time_q;
        min_value_d = min_value_q;
        scan_busy_d = scan_busy_q;
        scan_done_d = 1'b0;

        vld_pipe_d    = '0;
        vld_pipe_d[0] = bram_en_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end

        // Reads return in issue order, so a running count gives each sample its bin index.
        if (vld_pipe_q[RD_LATENCY-1]) begin
            rd_idx_d = rd_idx_q + 1'b1;
            first_d  = 1'b0;
            if (first_q || (bram_rddata < run_min_q)) begin
                run_min_d = bram_rddata;
                run_idx_d = rd_idx_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (scan_start) begin
                    last_addr_d = last_addr_calc;
                    bram_en_d   = 1'b1;
                    bram_addr_d = '0;
                    run_min_d   = '1;
                    run_idx_d   = '0;
                    rd_idx_d    = '0;
                    first_d     = 1'b1;
                    scan_busy_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bram_addr_q == last_addr_q) begin
                    bram_en_d   = 1'b0;
                    drain_cnt_d = '0;
                    state_d     = S_DRAIN;
                end else begin
                    bram_addr_d = bram_addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_END) begin
                    state_d = S_COMMIT;
                end else begin
                    drain_cnt_d = drain_cnt_q + 3'd1;
                end
            end
            S_COMMIT: begin
                low_time_d  = lt_wide[16:0];
                min_value_d = run_min_q;
                scan_done_d = 1'b1;
                scan_busy_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            last_addr_q <= '0;
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            vld_pipe_q  <= '0;
            drain_cnt_q <= '0;
            run_min_q   <= '0;
            run_idx_q   <= '0;
            rd_idx_q    <= '0;
            first_q     <= 1'b0;
            low_time_q  <= '0;
            min_value_q <= '0;
            scan_busy_q <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_addr_q <= last_addr_d;
            bram_en_q   <= bram_en_d;
            bram_addr_q <= bram_addr_d;
            vld_pipe_q  <= vld_pipe_d;
            drain_cnt_q <= drain_cnt_d;
            run_min_q   <= run_min_d;
            run_idx_q   <= run_idx_d;
            rd_idx_q    <= rd_idx_d;
            first_q     <= first_d;
            low_time_q  <= low_time_d;
            min_value_q <= min_value_d;
            scan_busy_q <= scan_busy_d;
            scan_done_q <= scan_done_d;
        end
    end

    assign bram_en   = bram_en_q;
    assign bram_addr = bram_addr_q;
    assign low_time  = low_time_q;
    assign min_value = min_value_q;
    assign scan_busy = scan_busy_q;
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_second_minimum_scan.sv
// Randomised and directed scans against a BRAM model; expectations are queued at scan start and checked on scan_done.
module tb_second_minimum_scan;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        scan_start = 1'b0;
    logic [16:0] msf_frequency = 17'd77500;
    logic        bram_en;
    logic [9:0]  bram_addr;
    logic [31:0] bram_rddata;
    logic [16:0] low_time;
    logic [31:0] min_value;
    logic        scan_busy;
    logic        scan_done;

    second_minimum_scan #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(10),
        .BIN_SHIFT (7),
        .RD_LATENCY(2)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .scan_start   (scan_start),
        .msf_frequency(msf_frequency),
        .bram_en      (bram_en),
        .bram_addr    (bram_addr),
        .bram_rddata  (bram_rddata),
        .low_time     (low_time),
        .min_value    (min_value),
        .scan_busy    (scan_busy),
        .scan_done    (scan_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Two-cycle BRAM read model
    logic [31:0] mem [0:1023];
    logic [31:0] rd_p0, rd_p1;
    always @(posedge clk) begin
        rd_p0 <= bram_en ? mem[bram_addr] : 32'd0;
        rd_p1 <= rd_p0;
    end
    assign bram_rddata = rd_p1;

    typedef struct {
        logic [16:0] lt;
        logic [31:0] mv;
        int          n;
        int          start_cyc;
        int          done_cyc;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: lowest-indexed minimum over the clamped bin range.
    task automatic ref_scan(input int freq, output exp_t e);
        int n;
        int best;
        n = (freq + 127) / 128;
        if (n < 1) n = 1;
        if (n > 1024) n = 1024;
        best = 0;
        for (int k = 1; k < n; k++) begin
            if (mem[k] < mem[best]) best = k;
        end
        e.n  = n;
        e.lt = 17'((best * 128) % 131072);
        e.mv = mem[best];
    endtask

    task automatic start_scan(input int freq);
        exp_t e;
        @(posedge clk);
        #1;
        msf_frequency = 17'(freq);
        ref_scan(freq, e);
        e.start_cyc = cyc;
        e.done_cyc  = cyc + e.n + 4;
        q.push_back(e);
        scan_start = 1'b1;
        @(posedge clk);
        #1;
        scan_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            chk("done_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    // Monitor
    int          exp_addr = 0;
    int          n_addr = 0;
    bit          addr_err = 0;
    bit          busy_err = 0;
    bit          idle_err = 0;
    bit          hold_err = 0;
    logic [16:0] last_lt = '0;
    logic [31:0] last_mv = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                exp_addr = 0;
                n_addr   = 0;
                addr_err = 0;
                busy_err = 0;
                last_lt  = '0;
                last_mv  = '0;
            end else begin
                if (bram_en) begin
                    if (int'(bram_addr) != exp_addr) addr_err = 1;
                    exp_addr++;
                    n_addr++;
                end
                if (q.size() > 0) begin
                    if (cyc > q[0].start_cyc && cyc < q[0].done_cyc && !scan_busy) busy_err = 1;
                end else if (scan_busy || bram_en) begin
                    idle_err = 1;
                end
                if (scan_done) begin
                    if (q.size() == 0) begin
                        chk("spurious_done", 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk("low_time", 64'(low_time), 64'(e.lt));
                        chk("min_value", 64'(min_value), 64'(e.mv));
                        chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                        chk("addr_count", 64'(n_addr), 64'(e.n));
                        chk("addr_order", 64'(addr_err), 64'd0);
                        chk("busy_window", 64'(busy_err || scan_busy), 64'd0);
                        last_lt = e.lt;
                        last_mv = e.mv;
                    end
                    exp_addr = 0;
                    n_addr   = 0;
                    addr_err = 0;
                    busy_err = 0;
                end else if (low_time != last_lt || min_value != last_mv) begin
                    hold_err = 1;
                end
            end
        end
    end

    task automatic fill_ramp();
        for (int k = 0; k < 1024; k++) mem[k] = 32'(1000 + k);
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 32'd0;
        #3;
        chk("reset_outputs", {bram_en, scan_busy, scan_done, 4'd0, low_time, min_value},
            64'd0);
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_low_time", 64'(low_time), 64'd0);
        chk("idle_no_activity", 64'(idle_err), 64'd0);

        // Nominal 77500 Hz, minimum at bin 300
        fill_ramp();
        mem[300] = 32'd5;
        start_scan(77500);
        wait_done(800);

        // Tie between bins 10 and 500
        fill_ramp();
        mem[10]  = 32'd0;
        mem[500] = 32'd0;
        start_scan(77500);
        wait_done(800);

        // Minimum at first and last bin
        fill_ramp();
        mem[0] = 32'd1;
        start_scan(77500);
        wait_done(800);
        fill_ramp();
        mem[605] = 32'd2;
        mem[606] = 32'd0;
        start_scan(77500);
        wait_done(800);

        // All bins all-ones
        for (int k = 0; k < 1024; k++) mem[k] = 32'hFFFF_FFFF;
        start_scan(77500);
        wait_done(800);

        // Retrigger at cycle 100 is ignored
        fill_ramp();
        mem[42] = 32'd7;
        start_scan(77500);
        repeat (98) @(posedge clk);
        #1;
        scan_start = 1'b1;
        @(posedge clk);
        #1;
        scan_start = 1'b0;
        wait_done(800);
        repeat (20) @(posedge clk);

        // Reset mid-scan aborts; a following scan completes
        fill_ramp();
        mem[123] = 32'd3;
        start_scan(77500);
        repeat (198) @(posedge clk);
        #1;
        aresetn = 1'b0;
        #1;
        chk("abort_outputs", {bram_en, scan_busy, 6'd0, low_time}, 64'd0);
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        start_scan(77500);
        wait_done(800);

        // Frequency boundaries
        fill_ramp();
        start_scan(100);
        wait_done(50);
        start_scan(0);
        wait_done(50);
        mem[1023] = 32'd9;
        start_scan(200000 % 131072 + 131071 - (200000 % 131072));
        wait_done(1200);

        // Frequency change mid-scan does not alter the scan
        fill_ramp();
        mem[400] = 32'd11;
        start_scan(77500);
        repeat (48) @(posedge clk);
        #1;
        msf_frequency = 17'd100;
        wait_done(800);

        // Randomised scans with frequent ties and all-ones words
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < 1024; k++) begin
                mem[k] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 300));
            end
            start_scan(int'($urandom_range(0, 131071)));
            wait_done(1200);
        end

        chk("hold_between_commits", 64'(hold_err), 64'd0);
        chk("idle_quiet", 64'(idle_err), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1);
    end

endmodule
